// File: rtl/servant_uart_rx_pkg.sv
// servant_uart_rx_pkg: shared types and register map for the servant UART receiver.
package servant_uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STATUS = 1'b1;
  localparam int LEVEL_LSB = 0;
  localparam int FULL_BIT = 5;
  localparam int OVR_BIT = 6;
  localparam int FERR_BIT = 7;
endpackage

// File: rtl/servant_uart_rx_fifo.sv
// servant_uart_rx_fifo: byte FIFO with wrap-bit pointers; a pop frees room for a same-cycle push.
module servant_uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_data,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_wr, w_rd;
  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);
  assign o_level = r_wptr - r_rptr;
  assign o_empty = r_wptr == r_rptr;
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge wb_clk)
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_wr);
      r_rptr <= r_rptr + AW'(w_rd);
    end
endmodule

// File: rtl/servant_uart_rx.sv
// servant_uart_rx: oversampling 8N1 UART receiver with byte FIFO, Wishbone registers and irq.
// Define SERVANT_UART_RX_FERR_EN to report framing errors in STATUS bit 7 and on o_irq.
module servant_uart_rx
  import servant_uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        i_rx,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
  rx_state_e r_state;
  logic r_rx_s1, r_rx_s2;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bits;
  logic [7:0] r_shift;
  logic r_ack, r_ovr, r_irq;
  logic [31:0] r_rdt, w_status;
  logic w_tick, w_stop, w_push, w_req, w_pop, w_wr_stat, w_ovr_set, w_ferr;
  logic w_full, w_empty, w_unused_dat;
  logic [7:0] w_dout;
  logic [AW:0] w_level;
  assign w_tick = r_cnt == '0;
  assign w_stop = (r_state == STOP) && w_tick;
  assign w_push = w_stop & r_rx_s2;
  assign w_req = i_wb_cyc & ~r_ack;
  assign w_pop = w_req & ~i_wb_we & (i_wb_adr == REG_DATA) & ~w_empty;
  assign w_wr_stat = w_req & i_wb_we & (i_wb_adr == REG_STATUS);
  assign w_ovr_set = w_push & w_full & ~w_pop;
  assign w_unused_dat = ^i_wb_dat;
  assign o_wb_rdt = r_rdt;
  assign o_wb_ack = r_ack;
  assign o_irq = r_irq;
  always_comb begin
    w_status = '0;
    w_status[LEVEL_LSB +: 5] = 5'(w_level);
    w_status[FULL_BIT] = w_full;
    w_status[OVR_BIT] = r_ovr;
    w_status[FERR_BIT] = w_ferr;
  end
  servant_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_shift),
    .o_data  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );
  // The counter free-runs downward; each state reloads it when it needs a new interval.
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_state <= IDLE;
      r_cnt <= '0;
      r_bits <= '0;
      r_shift <= '0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_cnt <= r_cnt - 1'b1;
      case (r_state)
        IDLE: if (!r_rx_s2) begin
          r_cnt <= HALF_LOAD;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_cnt <= BIT_LOAD;
          r_bits <= '0;
          r_state <= r_rx_s2 ? IDLE : DATA;
        end
        DATA: if (w_tick) begin
          r_cnt <= BIT_LOAD;
          r_shift <= {r_rx_s2, r_shift[7:1]};
          r_bits <= r_bits + 1'b1;
          if (r_bits == 3'd7) r_state <= STOP;
        end
        STOP: if (w_tick) r_state <= r_rx_s2 ? IDLE : BREAK;
        BREAK: if (r_rx_s2) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
      r_ovr <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req && !i_wb_we)
        r_rdt <= (i_wb_adr == REG_STATUS) ? w_status : w_empty ? '0 : {23'b0, 1'b1, w_dout};
      r_ovr <= w_ovr_set | (r_ovr & ~(w_wr_stat & i_wb_dat[OVR_BIT]));
      r_irq <= (w_level != '0) | w_ferr;
    end
`ifdef SERVANT_UART_RX_FERR_EN
  logic r_ferr;
  always_ff @(posedge wb_clk or negedge wb_rst_n)
    if (!wb_rst_n) r_ferr <= 1'b0;
    else r_ferr <= (w_stop & ~r_rx_s2) | (r_ferr & ~(w_wr_stat & i_wb_dat[FERR_BIT]));
  assign w_ferr = r_ferr;
`else
  assign w_ferr = 1'b0;
`endif
endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx: frame-level reference model of the UART receiver, checked every cycle.
module tb_servant_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  localparam int D = 4;
  localparam longint LAT = 3 + H + 9 * C;
`ifdef SERVANT_UART_RX_FERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic wb_clk = 1'b0, wb_rst_n = 1'b0, i_rx = 1'b1;
  logic i_wb_cyc = 1'b0, i_wb_we = 1'b0, i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = '0, o_wb_rdt;
  logic o_wb_ack, o_irq;
  servant_uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .i_rx    (i_rx),
    .i_wb_cyc(i_wb_cyc),
    .i_wb_we (i_wb_we),
    .i_wb_adr(i_wb_adr),
    .i_wb_dat(i_wb_dat),
    .o_wb_rdt(o_wb_rdt),
    .o_wb_ack(o_wb_ack),
    .o_irq   (o_irq)
  );
  always #5 wb_clk = ~wb_clk;
  typedef struct {
    longint t;
    logic [7:0] b;
    bit ok;
  } ev_t;
  int n_chk = 0, n_pass = 0;
  longint cyc = 0;
  ev_t evq[$];
  ev_t ev;
  logic [7:0] mq[$];
  logic [7:0] hb;
  bit m_ovr = 0, m_ferr = 0, m_ack = 0, ferr_pre, full_pre, pop, req, done;
  bit s_rst, s_cyc, s_we, s_adr;
  logic [31:0] s_dat, exp_rdt, rd_main, rd_aux;
  int lvl_pre;
  longint tp;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Reference model: bytes arrive LAT cycles after the start edge; Wishbone effects land on the ack edge.
  initial forever begin
    @(posedge wb_clk);
    cyc++;
    s_rst = wb_rst_n; s_cyc = i_wb_cyc; s_we = i_wb_we; s_adr = i_wb_adr; s_dat = i_wb_dat;
    #1;
    if (!s_rst) begin
      mq.delete(); evq.delete(); m_ovr = 0; m_ferr = 0; m_ack = 0;
      check("rst_ack", o_wb_ack, 0);
      check("rst_rdt", o_wb_rdt, 0);
      check("rst_irq", o_irq, 0);
    end else begin
      lvl_pre = mq.size(); ferr_pre = m_ferr; full_pre = lvl_pre == D; pop = 0;
      req = s_cyc && !m_ack;
      exp_rdt = '0;
      if (req && !s_we) begin
        if (s_adr) exp_rdt = {24'b0, FE & m_ferr, m_ovr, full_pre, 5'(lvl_pre)};
        else if (lvl_pre != 0) begin
          hb = mq.pop_front();
          exp_rdt = {23'b0, 1'b1, hb};
          pop = 1;
        end
      end
      if (req && s_we && s_adr) begin
        if (s_dat[6]) m_ovr = 0;
        if (s_dat[7]) m_ferr = 0;
      end
      while (evq.size() > 0 && evq[0].t <= cyc) begin
        ev = evq.pop_front();
        if (!ev.ok) m_ferr = m_ferr | FE;
        else if (full_pre && !pop) m_ovr = 1;
        else mq.push_back(ev.b);
      end
      m_ack = req;
      check("ack", o_wb_ack, m_ack);
      if (m_ack && !s_we) check("rdt", o_wb_rdt, exp_rdt);
      check("irq", o_irq, (lvl_pre != 0) || (FE && ferr_pre));
    end
  end
  task automatic wb(input bit we, input bit adr, input logic [31:0] dat, output logic [31:0] rd);
    bit got = 0;
    @(negedge wb_clk);
    i_wb_cyc = 1; i_wb_we = we; i_wb_adr = adr; i_wb_dat = dat;
    rd = '0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge wb_clk);
      #1;
      if (o_wb_ack) begin
        got = 1;
        rd = o_wb_rdt;
      end
    end
    i_wb_cyc = 0;
    if (!got) check("ack_timeout", 0, 1);
  endtask
  task automatic rd_chk(input string name, input bit adr, input logic [31:0] exp);
    logic [31:0] d;
    wb(0, adr, '0, d);
    check(name, d, exp);
  endtask
  task automatic send(input logic [7:0] b, input bit stop, input int hold);
    logic [9:0] f = {stop, b, 1'b0};
    @(negedge wb_clk);
    evq.push_back('{cyc + LAT, b, stop});
    for (int i = 0; i < 10; i++) begin
      i_rx = f[i];
      repeat (C) @(negedge wb_clk);
    end
    repeat (hold * C) @(negedge wb_clk);
    i_rx = 1;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1;
    // single frame, pop, interrupt release
    send(8'h55, 1, 0);
    check("irq_after_frame", o_irq, 1);
    rd_chk("data_55", 0, 32'h155);
    @(posedge wb_clk);
    #1;
    check("irq_after_pop", o_irq, 0);
    rd_chk("status_empty", 1, 32'h0);
    // short glitch is rejected
    @(negedge wb_clk);
    i_rx = 0;
    repeat (C / 4) @(negedge wb_clk);
    i_rx = 1;
    repeat (2 * C) @(negedge wb_clk);
    rd_chk("status_glitch", 1, 32'h0);
    // overflow
    for (int i = 1; i <= 5; i++) send(8'(i), 1, 0);
    rd_chk("status_ovr", 1, 32'h64);
    for (int i = 1; i <= 4; i++) rd_chk("data_fill", 0, 32'h100 | i);
    rd_chk("data_empty", 0, 32'h0);
    wb(1, 1, 32'h40, rd_main);
    rd_chk("status_ovr_clr", 1, 32'h0);
    // held ack request alternates
    @(negedge wb_clk);
    i_wb_cyc = 1; i_wb_we = 0; i_wb_adr = 1;
    repeat (6) @(negedge wb_clk);
    i_wb_cyc = 0;
    // framing error then a 3-bit break
    send(8'hA3, 0, 3);
    rd_chk("status_ferr", 1, FE ? 32'h80 : 32'h0);
    check("irq_ferr", o_irq, FE);
    wb(1, 1, 32'h80, rd_main);
    @(posedge wb_clk);
    #1;
    check("irq_ferr_clr", o_irq, 0);
    rd_chk("status_ferr_clr", 1, 32'h0);
    rd_chk("data_after_break", 0, 32'h0);
    // reset in the middle of data bit 4 with a byte queued
    send(8'h77, 1, 0);
    @(negedge wb_clk);
    i_rx = 0;
    repeat (C) @(negedge wb_clk);
    for (int i = 0; i < 4; i++) begin
      i_rx = i[0];
      repeat (C) @(negedge wb_clk);
    end
    i_rx = 0;
    repeat (H) @(negedge wb_clk);
    wb_rst_n = 0;
    i_rx = 1;
    #1;
    check("async_rst_irq", o_irq, 0);
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1;
    rd_chk("status_post_rst", 1, 32'h0);
    send(8'h3C, 1, 0);
    rd_chk("data_3c", 0, 32'h13C);
    // pop coincides with a push into a full FIFO
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    send(8'h33, 1, 0);
    send(8'h44, 1, 0);
    @(negedge wb_clk);
    tp = cyc + 1 + LAT;
    fork
      send(8'h55, 1, 0);
      begin
        while (cyc < tp - 2) @(negedge wb_clk);
        wb(0, 0, '0, rd_aux);
        check("data_pop_push", rd_aux, 32'h111);
      end
    join
    rd_chk("status_pop_push", 1, 32'h24);
    rd_chk("data_22", 0, 32'h122);
    rd_chk("data_33", 0, 32'h133);
    rd_chk("data_44", 0, 32'h144);
    rd_chk("data_55b", 0, 32'h155);
    // randomized traffic against the model
    done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(8'($urandom), $urandom_range(0, 7) != 0, 0);
          repeat ($urandom_range(0, 2 * C)) @(negedge wb_clk);
        end
        done = 1;
      end
      begin
        int k;
        while (!done) begin
          repeat ($urandom_range(1, 60)) @(negedge wb_clk);
          k = $urandom_range(0, 9);
          if (k < 6) wb(0, 0, '0, rd_aux);
          else if (k < 8) wb(0, 1, '0, rd_aux);
          else wb(1, k[0], $urandom, rd_aux);
        end
      end
    join
    repeat (2 * C) @(negedge wb_clk);
    for (int i = 0; i < D + 2; i++) wb(0, 0, '0, rd_main);
    wb(1, 1, 32'hC0, rd_main);
    rd_chk("status_final", 1, 32'h0);
    repeat (4) @(negedge wb_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/servant_uart_rx.md
# servant_uart_rx

UART receiver peripheral for the servant SoC: the receive-side counterpart of the bit-banged serial TX output. It oversamples an asynchronous 8N1 serial line and queues received bytes in a small FIFO. The FIFO is read by the SERV core over a Wishbone slave port, and an interrupt is raised while data is pending. It sits beside the GPIO/timer slaves on the servant peripheral bus.

## Interface
Parameters:
- CLKS_PER_BIT, 139: wb_clk cycles per bit (16 MHz / 115200); legal range ≥ 8.
- FIFO_DEPTH, 4: receive FIFO entries; power of two, 2..16.

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- i_rx  in  1  serial input; idles high.
- i_wb_cyc  in  1  Wishbone cycle/strobe (combined).
- i_wb_we  in  1  write enable.
- i_wb_adr  in  1  register select: 0 = DATA, 1 = STATUS.
- i_wb_dat  in  32  write data.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_irq  out  1  high while the FIFO is non-empty.

## Operation
- i_rx passes through a 2-FF synchronizer. Both flops reset to 1.
- RX state machine:
  - IDLE: a synchronized low starts a frame; the bit counter is loaded with CLKS_PER_BIT/2 − 1 and the state moves to START.
  - START: at counter expiry, a low sample means a valid start; go to DATA with 8 bits pending. A high sample is a glitch; return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, shifting into an 8-bit register. After bit 7, go to STOP.
  - STOP: sample at the bit midpoint.
    - High: push the byte, then go to IDLE.
    - Low: framing error; drop the byte and go to BREAK.
  - BREAK: wait for a synchronized high, then go to IDLE. This prevents a held-low line from producing repeated frames.
- FIFO push with FIFO full: byte dropped, sticky OVR set. A simultaneous pop and push on a full FIFO is legal: no drop, no OVR.
- Wishbone:
  - o_wb_ack pulses one cycle after i_wb_cyc and is never asserted two cycles back-to-back.
  - DATA read: {23'b0, valid, byte}. When valid, the read pops the FIFO. Reading an empty FIFO returns 0 with no side effect.
  - STATUS read: {24'b0, FERR, OVR, FULL, 5-bit level}.
  - STATUS write: a 1 in bit 6 clears OVR; a 1 in bit 7 clears FERR. A write and a same-cycle set resolve in favour of the set.
  - DATA writes are acked and ignored.
- o_irq = registered (level ≠ 0).

## Timing
- Reset values: o_wb_ack 0, o_wb_rdt 0, o_irq 0. Internal state: FSM IDLE, FIFO empty, OVR/FERR 0.
- Reset applied mid-frame discards the partial byte and all queued bytes.
- Start-edge-to-FIFO-visible latency: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. o_irq follows one cycle later.
- Read data is registered and valid in the o_wb_ack cycle. A pop takes effect in that same cycle.
- Level arithmetic uses log2(FIFO_DEPTH)+1-bit pointers and wraps modulo 2·FIFO_DEPTH. Full = MSBs differ and low bits equal.

## Configuration
- SERVANT_UART_RX_FERR_EN defined:
  - A framing error sets sticky FERR (STATUS bit 7).
  - o_irq = (level ≠ 0) | FERR.
- Not defined:
  - Framing errors silently drop the byte.
  - STATUS bit 7 reads 0 and writes to it are ignored.
  - o_irq reflects FIFO level only.

## Structure
- Package servant_uart_rx_pkg holds:
  - the RX state enum (IDLE, START, DATA, STOP, BREAK);
  - register address constants (REG_DATA = 0, REG_STATUS = 1);
  - STATUS bit positions (LEVEL_LSB = 0, FULL_BIT = 5, OVR_BIT = 6, FERR_BIT = 7).
- Sub-module servant_uart_rx_fifo: synchronous FIFO, 8-bit wide and FIFO_DEPTH deep, with push/pop/full/level ports. Same clock and async active-low reset.

## Test plan
- Frame 0x55 at CLKS_PER_BIT=16, then DATA read → o_wb_rdt = 0x155, o_irq drops the cycle after the pop, STATUS level = 0.
- 0.25-bit low glitch on idle line → FSM returns to IDLE, no push, STATUS = 0.
- Five back-to-back frames 0x01..0x05 with FIFO_DEPTH=4, no reads → FULL = 1, OVR = 1; reads return 0x101..0x104, then 0x000.
- Frame 0xA3 with stop bit low, macro defined → no push, FERR = 1, o_irq = 1. STATUS write 0x80 → FERR = 0, o_irq = 0. Line held low 3 bit times produces no further frames.
- wb_rst_n asserted during DATA bit 4 and released → outputs 0. The next clean 0x3C frame is received intact.
- Pop on the same cycle as the stop-bit push with a full FIFO → level stays 4, OVR = 0, byte order preserved.
